// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared types and constants for the RISC-V single-cycle core.
//            XLEN           - architectural register / address width
//            INSTR_EBREAK   - EBREAK encoding, used to stop instruction fetch
//            fetch_state_t  - fetch stage state encoding (BOOT, RUN, HALT)
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/pc_next_logic.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_logic
// Purpose  : Combinational next-PC selection for the fetch stage.
// Ports    : pc             in  current byte PC
//            fetch          in  an instruction is captured this cycle
//            redirect_valid in  branch/jump redirect request (highest priority)
//            redirect_pc    in  redirect target byte address
//            halt_detect    in  the captured instruction halts fetch
//            pc_next        out PC value to load at the next edge
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_logic
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            fetch,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_detect,
    output logic [XLEN-1:0] pc_next
);

    localparam logic [XLEN-1:0] c_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] c_PC_STEP    = XLEN'(4);

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            // Misaligned targets are silently word-aligned.
            pc_next = redirect_pc & c_ALIGN_MASK;
        end else if (fetch && !halt_detect) begin
            // A halting instruction keeps pc parked on its own address.
            pc_next = pc + c_PC_STEP;
        end
    end

endmodule : pc_next_logic
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Owns the PC, addresses the combinational
//            instruction memory and registers {pc, instr} into the IF/ID
//            holding register with a valid/ready handshake toward decode.
//            Supports redirects and halts on HALT_INSTR (EBREAK).
// Ports    : clock          in  rising-edge clock, shared with imem
//            reset_n        in  asynchronous active-low reset
//            imem_addr      out word index into imem
//            imem_instr     in  combinational imem read data
//            redirect_valid in  one-cycle redirect request
//            redirect_pc    in  redirect byte address
//            id_valid       out IF/ID register holds an instruction
//            id_ready       in  decode accepts the instruction
//            id_pc          out byte address of id_instr
//            id_instr       out fetched instruction
//            halted         out fetch is stopped
//            fault          out sticky out-of-range fetch flag
// Config   : FETCH_BOUND_CHECK_EN - when defined, fetches beyond IMEM_DEPTH
//            words halt the stage and raise fault; otherwise the imem address
//            wraps modulo IMEM_DEPTH and fault is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              IMEM_DEPTH = 32,
    parameter logic [XLEN-1:0] HALT_INSTR = INSTR_EBREAK
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic            halted,
    output logic            fault
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_id_valid;
    logic [XLEN-1:0] r_id_pc;
    logic [XLEN-1:0] r_id_instr;
    logic            r_halted;

    logic [XLEN-1:0] w_word_idx;
    logic            w_fetch;
    logic            w_oob;
    logic            w_capture;
    logic            w_halt_detect;
    logic [XLEN-1:0] w_pc_next;

    assign w_word_idx = {2'b00, r_pc[XLEN-1:2]};

`ifdef FETCH_BOUND_CHECK_EN
    logic r_fault;
    assign w_oob     = (w_word_idx >= XLEN'(IMEM_DEPTH));
    assign imem_addr = w_word_idx;
    assign fault     = r_fault;
`else
    assign w_oob     = 1'b0;
    assign imem_addr = w_word_idx & XLEN'(IMEM_DEPTH - 1);
    assign fault     = 1'b0;
`endif

    // A fetch slot exists when running, not being redirected, and the IF/ID
    // register is empty or being drained this cycle.
    assign w_fetch       = (r_state == RUN) && !redirect_valid && (!r_id_valid || id_ready);
    assign w_capture     = w_fetch && !w_oob;
    assign w_halt_detect = w_capture && (imem_instr == HALT_INSTR);

    pc_next_logic u_pc_next (
        .pc             (r_pc),
        .fetch          (w_capture),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_detect    (w_halt_detect),
        .pc_next        (w_pc_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_instr <= '0;
            r_halted   <= 1'b0;
`ifdef FETCH_BOUND_CHECK_EN
            r_fault    <= 1'b0;
`endif
        end else begin
            r_pc <= w_pc_next;
            if (redirect_valid) begin
                // Flush wins over any pending accept.
                r_id_valid <= 1'b0;
                r_state    <= RUN;
                r_halted   <= 1'b0;
            end else if (w_capture) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= r_pc;
                r_id_instr <= imem_instr;
                if (w_halt_detect) begin
                    r_state  <= HALT;
                    r_halted <= 1'b1;
                end
            end else begin
                if (r_id_valid && id_ready) begin
                    r_id_valid <= 1'b0;
                end
                if (w_fetch && w_oob) begin
                    r_state  <= HALT;
                    r_halted <= 1'b1;
`ifdef FETCH_BOUND_CHECK_EN
                    r_fault  <= 1'b1;
`endif
                end else if (r_state == BOOT) begin
                    r_state <= RUN;
                end
            end
        end
    end

    assign id_valid = r_id_valid;
    assign id_pc    = r_id_pc;
    assign id_instr = r_id_instr;
    assign halted   = r_halted;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A small imem model drives
//            imem_instr; expected {pc, instr} pairs are queued as stimulus is
//            set up and popped whenever decode accepts an instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_ADD    = 32'h0020_81b3;
    localparam logic [31:0] c_SUB    = 32'h4020_8233;
    localparam logic [31:0] c_OR     = 32'h0020_e2b3;
    localparam logic [31:0] c_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        halted;
    logic        fault;

    logic [31:0] mem [32];
    exp_t        sb_q [$];
    int          errors;
    int          checks;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (32),
        .HALT_INSTR (32'h0010_0073)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .halted         (halted),
        .fault          (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        imem_instr = 32'hdead_beef;
        if (imem_addr < 32'd32) imem_instr = mem[imem_addr[4:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Consume the accepted instruction (if any) against the scoreboard, then
    // advance one clock and settle just past the edge.
    task automatic cyc();
        exp_t e;
        if (id_valid === 1'b1 && id_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_pc", id_pc, 32'hffff_ffff);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", id_pc, e.pc);
                chk("sb_instr", id_instr, e.instr);
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0013 | (32'(i) << 7);
        mem[0] = c_ADD;
        mem[1] = c_SUB;
        mem[2] = c_OR;
        mem[3] = c_EBREAK;

        reset_n        = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        cyc();
        cyc();
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);

        // Straight-line flow
        reset_n  = 1'b1;
        id_ready = 1'b1;
        cyc();
        chk("boot_no_capture", {31'b0, id_valid}, 32'd0);
        sb_q.push_back('{pc: 32'h0, instr: c_ADD});
        sb_q.push_back('{pc: 32'h4, instr: c_SUB});
        cyc();
        chk("first_valid", {31'b0, id_valid}, 32'd1);
        chk("first_pc", id_pc, 32'h0);
        cyc();
        chk("second_pc", id_pc, 32'h4);

        // Back-pressure at id_pc=4
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", id_pc, 32'h4);
            chk("stall_instr", id_instr, c_SUB);
            chk("stall_addr", imem_addr, 32'd2);
        end
        sb_q.push_back('{pc: 32'h8, instr: c_OR});
        sb_q.push_back('{pc: 32'hc, instr: c_EBREAK});
        id_ready = 1'b1;
        cyc();
        chk("release_pc", id_pc, 32'h8);

        // Halt on EBREAK
        cyc();
        chk("ebreak_pc", id_pc, 32'hc);
        chk("ebreak_halted", {31'b0, halted}, 32'd1);
        chk("ebreak_addr", imem_addr, 32'd3);
        cyc();
        chk("halt_drain_valid", {31'b0, id_valid}, 32'd0);
        chk("halt_addr_hold", imem_addr, 32'd3);
        cyc();
        chk("halt_no_fetch", {31'b0, id_valid}, 32'd0);
        chk("halt_still", {31'b0, halted}, 32'd1);

        // Redirect out of HALT to 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        chk("restart_halted", {31'b0, halted}, 32'd0);
        chk("restart_addr", imem_addr, 32'd0);
        sb_q.push_back('{pc: 32'h0, instr: c_ADD});
        cyc();
        chk("restart_pc", id_pc, 32'h0);
        cyc();
        chk("pre_redirect_valid", {31'b0, id_valid}, 32'd1);

        // Redirect to a misaligned target while an instruction is pending
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h16;
        cyc();
        redirect_valid = 1'b0;
        chk("redir_flush", {31'b0, id_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'd5);
        sb_q.push_back('{pc: 32'h14, instr: mem[5]});
        sb_q.push_back('{pc: 32'h18, instr: mem[6]});
        cyc();
        chk("redir_pc", id_pc, 32'h14);
        id_ready = 1'b1;
        cyc();
        cyc();
        id_ready = 1'b0;
        cyc();
        chk("stall2_pc", id_pc, 32'h1c);
        chk("stall2_valid", {31'b0, id_valid}, 32'd1);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset mid-stall, no clock edge in between
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_id_valid", {31'b0, id_valid}, 32'd0);
        chk("async_id_pc", id_pc, 32'd0);
        chk("async_id_instr", id_instr, 32'd0);
        chk("async_halted", {31'b0, halted}, 32'd0);
        chk("async_addr", imem_addr, 32'd0);

        // Out-of-range fetch
        cyc();
        reset_n  = 1'b1;
        id_ready = 1'b1;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        cyc();
        redirect_valid = 1'b0;
`ifdef FETCH_BOUND_CHECK_EN
        chk("oob_addr", imem_addr, 32'd32);
        cyc();
        chk("oob_fault", {31'b0, fault}, 32'd1);
        chk("oob_halted", {31'b0, halted}, 32'd1);
        chk("oob_no_valid", {31'b0, id_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        chk("oob_redir_halted", {31'b0, halted}, 32'd0);
        chk("oob_fault_sticky", {31'b0, fault}, 32'd1);
`else
        chk("wrap_addr", imem_addr, 32'd0);
        sb_q.push_back('{pc: 32'h80, instr: c_ADD});
        cyc();
        chk("wrap_valid", {31'b0, id_valid}, 32'd1);
        chk("wrap_pc", id_pc, 32'h80);
        chk("wrap_fault", {31'b0, fault}, 32'd0);
        cyc();
        chk("wrap_sb_drained", 32'(sb_q.size()), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
